// File: rtl/sram_port_arbiter.sv
// Two-client round-robin arbiter and setup/strobe/recover sequencer for a single-port SRAM.
// Optional SRAM_ARB_LOCK_EN adds lock_a/lock_b so an owner can keep the SRAM across accesses.
module sram_port_arbiter #(
    parameter int unsigned AW      = 11,
    parameter int unsigned DW      = 16,
    parameter int unsigned ACC_CYC = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          we_a,
    input  logic          we_b,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_a,
    input  logic [DW-1:0] wdata_b,
`ifdef SRAM_ARB_LOCK_EN
    input  logic          lock_a,
    input  logic          lock_b,
`endif
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          done_a,
    output logic          done_b,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] address,
    inout  wire  [DW-1:0] sram_data,
    output logic          rd,
    output logic          wr
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StRecover} state_e;

    localparam logic [3:0] AccLoad = 4'(ACC_CYC - 32'd1);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          owner_q, owner_d;       // 0 = A, 1 = B
    logic          last_gnt_q, last_gnt_d; // 0 = A, 1 = B
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
    logic          done_a_q, done_a_d, done_b_q, done_b_d;
    logic          pick_b;

`ifdef SRAM_ARB_LOCK_EN
    logic hold_q, hold_d;

    always_comb begin
        if (hold_q && (owner_q ? req_b : req_a)) begin
            pick_b = owner_q;
        end else begin
            pick_b = req_b && (!req_a || !last_gnt_q);
        end
    end
`else
    // Tie goes to whichever client was not served last.
    assign pick_b = req_b && (!req_a || !last_gnt_q);
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        gnt_a_d    = gnt_a_q;
        gnt_b_d    = gnt_b_q;
        done_a_d   = 1'b0;
        done_b_d   = 1'b0;
`ifdef SRAM_ARB_LOCK_EN
        hold_d     = hold_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_a || req_b) begin
                    state_d = StSetup;
                    owner_d = pick_b;
                    we_d    = pick_b ? we_b : we_a;
                    addr_d  = pick_b ? addr_b : addr_a;
                    wdata_d = pick_b ? wdata_b : wdata_a;
                    gnt_a_d = !pick_b;
                    gnt_b_d = pick_b;
`ifdef SRAM_ARB_LOCK_EN
                    hold_d  = 1'b0;
`endif
                end
            end
            StSetup: begin
                state_d = StAccess;
                cnt_d   = AccLoad;
            end
            StAccess: begin
                if (cnt_q == 4'd0) begin
                    state_d  = StRecover;
                    done_a_d = !owner_q;
                    done_b_d = owner_q;
                    if (!we_q) begin
                        rdata_d = sram_data;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StRecover: begin
                state_d    = StIdle;
                gnt_a_d    = 1'b0;
                gnt_b_d    = 1'b0;
                last_gnt_d = owner_q;
`ifdef SRAM_ARB_LOCK_EN
                hold_d     = owner_q ? (req_b && lock_b) : (req_a && lock_a);
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            owner_q    <= 1'b0;
            last_gnt_q <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            done_a_q   <= 1'b0;
            done_b_q   <= 1'b0;
`ifdef SRAM_ARB_LOCK_EN
            hold_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            gnt_a_q    <= gnt_a_d;
            gnt_b_q    <= gnt_b_d;
            done_a_q   <= done_a_d;
            done_b_q   <= done_b_d;
`ifdef SRAM_ARB_LOCK_EN
            hold_q     <= hold_d;
`endif
        end
    end

    // Strobes and data enable come straight from registered state: glitch-free.
    assign rd        = !((state_q == StAccess) && !we_q);
    assign wr        = !((state_q == StAccess) && we_q);
    assign sram_data = ((state_q == StAccess) && we_q) ? wdata_q : {DW{1'bz}};

    assign gnt_a   = gnt_a_q;
    assign gnt_b   = gnt_b_q;
    assign done_a  = done_a_q;
    assign done_b  = done_b_q;
    assign rdata   = rdata_q;
    assign address = addr_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: transaction-level model checked every cycle plus directed tests.
// Build with SRAM_ARB_LOCK_EN defined to also exercise the lock ports.
module tb_sram_port_arbiter;

    localparam int ACC = 1;
    localparam logic [15:0] REL = 16'hFFFF; // released bus reads as pulled-up

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_a = 0, req_b = 0, we_a = 0, we_b = 0, lock_a = 0, lock_b = 0;
    logic [10:0] addr_a = 0, addr_b = 0;
    logic [15:0] wdata_a = 0, wdata_b = 0;
    logic        gnt_a, gnt_b, done_a, done_b, rd, wr;
    logic [15:0] rdata;
    logic [10:0] address;
    wire  [15:0] sram_data;

    logic        req_a2 = 0, we_a2 = 0, zero1 = 0;
    logic [10:0] addr_a2 = 0, zero_a = 0;
    logic [15:0] wdata_a2 = 0, zero_d = 0;
    logic        gnt_a2, gnt_b2, done_a2, done_b2, rd2, wr2;
    logic [15:0] rdata2;
    logic [10:0] address2;
    wire  [15:0] sram_data2;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.AW(11), .DW(16), .ACC_CYC(ACC)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
`ifdef SRAM_ARB_LOCK_EN
        .lock_a(lock_a), .lock_b(lock_b),
`endif
        .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
        .rdata(rdata), .address(address), .sram_data(sram_data), .rd(rd), .wr(wr)
    );

    sram_port_arbiter #(.AW(11), .DW(16), .ACC_CYC(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_a(req_a2), .req_b(zero1), .we_a(we_a2), .we_b(zero1),
        .addr_a(addr_a2), .addr_b(zero_a), .wdata_a(wdata_a2), .wdata_b(zero_d),
`ifdef SRAM_ARB_LOCK_EN
        .lock_a(zero1), .lock_b(zero1),
`endif
        .gnt_a(gnt_a2), .gnt_b(gnt_b2), .done_a(done_a2), .done_b(done_b2),
        .rdata(rdata2), .address(address2), .sram_data(sram_data2), .rd(rd2), .wr(wr2)
    );

    for (genvar gi = 0; gi < 16; gi++) begin : g_pu
        pullup (sram_data[gi]);
        pullup (sram_data2[gi]);
    end

    // External SRAM: drives the bus while rd is low, stores on write; pl_* is a backdoor preload.
    logic [15:0] sram_mem [0:2047];
    logic        pl_en = 1'b0;
    logic [10:0] pl_addr = 0;
    logic [15:0] pl_data = 0;
    assign sram_data = (!rd) ? sram_mem[address] : 16'bz;

    always @(posedge clk) begin
        if (pl_en) sram_mem[pl_addr] <= pl_data;
        else if (!wr) sram_mem[address] <= sram_data;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction model: m_k counts cycles since grant (0 setup, 1..ACC access, ACC+1 recover).
    logic        m_busy, m_own, m_we, m_last, m_hold;
    int          m_k;
    logic [10:0] m_addr;
    logic [15:0] m_wdata, m_rdata;
    logic [15:0] exp_mem [0:2047];

    function automatic logic pick_b(input logic ra, input logic rb, input logic la, input logic lb);
        if (m_hold && (m_own ? rb : ra)) return m_own;
        if (ra && rb) return !m_last;
        return rb;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 0; m_own <= 0; m_we <= 0; m_last <= 1; m_hold <= 0;
            m_k <= 0; m_addr <= 0; m_wdata <= 0; m_rdata <= 0;
        end else if (!m_busy) begin
            if (pl_en) exp_mem[pl_addr] <= pl_data;
            if (req_a || req_b) begin
                m_busy  <= 1; m_k <= 0; m_hold <= 0;
                m_own   <= pick_b(req_a, req_b, lock_a, lock_b);
                m_we    <= pick_b(req_a, req_b, lock_a, lock_b) ? we_b : we_a;
                m_addr  <= pick_b(req_a, req_b, lock_a, lock_b) ? addr_b : addr_a;
                m_wdata <= pick_b(req_a, req_b, lock_a, lock_b) ? wdata_b : wdata_a;
            end
        end else if (m_k == ACC + 1) begin
            m_busy <= 0;
            m_last <= m_own;
`ifdef SRAM_ARB_LOCK_EN
            m_hold <= m_own ? (req_b && lock_b) : (req_a && lock_a);
`endif
        end else begin
            if (m_k == ACC) begin
                if (m_we) exp_mem[m_addr] <= m_wdata;
                else m_rdata <= exp_mem[m_addr];
            end
            m_k <= m_k + 1;
        end
    end

    wire m_acc = m_busy && (m_k >= 1) && (m_k <= ACC);

    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt_a", gnt_a, m_busy && !m_own);
            check("gnt_b", gnt_b, m_busy && m_own);
            check("done_a", done_a, m_busy && (m_k == ACC + 1) && !m_own);
            check("done_b", done_b, m_busy && (m_k == ACC + 1) && m_own);
            check("rd", rd, !(m_acc && !m_we));
            check("wr", wr, !(m_acc && m_we));
            check("address", address, m_addr);
            check("rdata", rdata, m_rdata);
            if (m_acc && m_we) check("sram_data write", sram_data, m_wdata);
            else if (!m_acc) check("sram_data released", sram_data, REL);
        end
    end

    int   wr_low, rd_low, done_at, ng, nd, both_low, na;
    logic pa, pb;
    logic order [0:3];
    int   dcyc [0:3];

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        check("reset gnt_a", gnt_a, 0);
        check("reset rd", rd, 1);
        check("reset wr", wr, 1);
        check("reset address", address, 0);
        check("reset rdata", rdata, 0);
        check("reset sram_data", sram_data, REL);

        // Single write from A
        req_a = 1; we_a = 1; addr_a = 11'h005; wdata_a = 16'hA5A5;
        for (int i = 0; i < 10 && !gnt_a; i++) @(negedge clk);
        check("t1 gnt_a", gnt_a, 1);
        wr_low = 0; done_at = -1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (!wr) begin
                wr_low++;
                check("t1 address", address, 11'h005);
                check("t1 data", sram_data, 16'hA5A5);
            end
            if (done_a && done_at < 0) done_at = i;
            if (done_a) req_a = 0;
        end
        check("t1 wr low cycles", wr_low, 1);
        check("t1 grant cycle of done_a", done_at + 1, 3);

        // Single read from B
        pl_addr = 11'h005; pl_data = 16'h1234; pl_en = 1;
        @(negedge clk);
        pl_en = 0;
        req_b = 1; we_b = 0; addr_b = 11'h005;
        for (int i = 0; i < 10 && !gnt_b; i++) @(negedge clk);
        check("t2 gnt_b", gnt_b, 1);
        rd_low = 0; done_at = -1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (!rd) rd_low++;
            if (done_b) begin
                done_at = i;
                check("t2 rdata at done", rdata, 16'h1234);
                req_b = 0;
            end
        end
        check("t2 rd low cycles", rd_low, ACC);
        check("t2 done_b seen", done_at, 2);
        check("t2 rdata held", rdata, 16'h1234);

        // Both requesting: round robin
        req_a = 1; we_a = 1; addr_a = 11'h010; wdata_a = 16'h0BEE;
        req_b = 1; we_b = 0; addr_b = 11'h010;
        ng = 0; nd = 0; both_low = 0; pa = 0; pb = 0;
        for (int c = 0; c < 40 && nd < 4; c++) begin
            @(negedge clk);
            if (gnt_a && !pa && ng < 4) begin order[ng] = 0; ng++; end
            if (gnt_b && !pb && ng < 4) begin order[ng] = 1; ng++; end
            pa = gnt_a; pb = gnt_b;
            if ((done_a || done_b) && nd < 4) begin dcyc[nd] = c; nd++; end
            if (!rd && !wr) both_low++;
        end
        req_a = 0; req_b = 0;
        check("t3 grants", ng, 4);
        check("t3 order 0", order[0], 0);
        check("t3 order 1", order[1], 1);
        check("t3 order 2", order[2], 0);
        check("t3 order 3", order[3], 1);
        for (int k = 1; k < 4; k++) check("t3 done spacing", dcyc[k] - dcyc[k-1], 4);
        check("t3 rd wr both low", both_low, 0);
        check("t3 read of A write", rdata, 16'h0BEE);

        // ACC_CYC=3 write on second instance
        req_a2 = 1; we_a2 = 1; addr_a2 = 11'h007; wdata_a2 = 16'h5A5A;
        for (int i = 0; i < 10 && !gnt_a2; i++) @(negedge clk);
        check("t4 gnt_a2", gnt_a2, 1);
        check("t4 setup wr2", wr2, 1);
        check("t4 setup data2", sram_data2, REL);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4 access wr2", wr2, 0);
            check("t4 access rd2", rd2, 1);
            check("t4 access data2", sram_data2, 16'h5A5A);
            check("t4 access address2", address2, 11'h007);
        end
        @(negedge clk);
        check("t4 recover wr2", wr2, 1);
        check("t4 recover data2", sram_data2, REL);
        check("t4 recover done_a2", done_a2, 1);
        req_a2 = 0;

        // Reset in the middle of an access
        req_a = 1; we_a = 1; addr_a = 11'h014; wdata_a = 16'h00C3;
        for (int i = 0; i < 10 && !gnt_a; i++) @(negedge clk);
        @(negedge clk);
        check("t5 in access wr", wr, 0);
        #2 rst = 0;
        #1;
        check("t5 async rd", rd, 1);
        check("t5 async wr", wr, 1);
        check("t5 async gnt_a", gnt_a, 0);
        check("t5 async sram_data", sram_data, REL);
        check("t5 async rdata", rdata, 0);
        req_b = 1;
        done_at = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done_a || done_b) done_at++;
        end
        rst = 1;
        for (int i = 0; i < 10 && !(gnt_a || gnt_b); i++) begin
            @(negedge clk);
            if (done_a || done_b) done_at++;
        end
        check("t5 no done", done_at, 0);
        check("t5 tie gnt_a", gnt_a, 1);
        check("t5 tie gnt_b", gnt_b, 0);
        req_b = 0;
        for (int i = 0; i < 10 && !done_a; i++) @(negedge clk);
        check("t5 done_a", done_a, 1);
        req_a = 0;

`ifdef SRAM_ARB_LOCK_EN
        // Lock keeps A granted; fairness resumes once lock drops
        req_b = 1; we_b = 0; addr_b = 11'h005;
        for (int i = 0; i < 12 && !done_b; i++) @(negedge clk);
        req_b = 0;
        @(negedge clk);
        lock_a = 1; req_a = 1; req_b = 1;
        ng = 0; na = 0; pa = 0; pb = 0;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            @(negedge clk);
            if (gnt_a && !pa) begin
                order[ng] = 0; ng++; na++;
                if (na == 3) lock_a = 0;
            end
            if (gnt_b && !pb && ng < 4) begin order[ng] = 1; ng++; end
            pa = gnt_a; pb = gnt_b;
        end
        req_a = 0; req_b = 0;
        check("t6 grants", ng, 4);
        check("t6 order 0", order[0], 0);
        check("t6 order 1", order[1], 0);
        check("t6 order 2", order[2], 0);
        check("t6 order 3", order[3], 1);
        repeat (8) @(negedge clk);
`endif

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
